serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell, LSB-first, valid/ready in and out.
// Optional macro SERIAL_ADD_SUB_EN adds op_sub_in for a - b via inverted B and forced carry-in.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             start_valid_in,
   output logic             start_ready_out,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             op_sub_in,
`endif
   output logic             result_valid_out,
   input  logic             result_ready_in,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             busy_out
);

   localparam int CW = $clog2(WIDTH + 1);
   // The counter runs one past the last bit so the DONE transition lands WIDTH+1 edges after accept.
   localparam logic [CW-1:0] CNT_END = CW'(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_sr_r;
   logic [WIDTH-1:0] b_sr_r;
   logic [WIDTH-1:0] sum_sr_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;

   logic             ha1_sum_s;
   logic             ha1_carry_s;
   logic             ha2_carry_s;
   logic             fa_sum_s;
   logic             fa_carry_s;
   logic [WIDTH-1:0] b_load_s;
   logic             carry_load_s;

   // Full-adder cell: two half adders plus an OR on their carries.
   xor g_ha1_x (ha1_sum_s,   a_sr_r[0], b_sr_r[0]);
   and g_ha1_a (ha1_carry_s, a_sr_r[0], b_sr_r[0]);
   xor g_ha2_x (fa_sum_s,    ha1_sum_s, carry_r);
   and g_ha2_a (ha2_carry_s, ha1_sum_s, carry_r);
   or  g_fa_o  (fa_carry_s,  ha1_carry_s, ha2_carry_s);

`ifdef SERIAL_ADD_SUB_EN
   // Subtraction is a + ~b + 1, so the operator only changes what gets loaded.
   assign b_load_s     = op_sub_in ? ~b_in : b_in;
   assign carry_load_s = op_sub_in ? 1'b1  : cin_in;
`else
   assign b_load_s     = b_in;
   assign carry_load_s = cin_in;
`endif

   // Controller FSM, datapath shift registers and registered handshake outputs.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_r          <= ST_IDLE;
         a_sr_r           <= '0;
         b_sr_r           <= '0;
         sum_sr_r         <= '0;
         carry_r          <= 1'b0;
         cnt_r            <= '0;
         start_ready_out  <= 1'b1;
         result_valid_out <= 1'b0;
         sum_out          <= '0;
         carry_out        <= 1'b0;
         busy_out         <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_valid_in) begin
                  a_sr_r          <= a_in;
                  b_sr_r          <= b_load_s;
                  carry_r         <= carry_load_s;
                  cnt_r           <= '0;
                  state_r         <= ST_RUN;
                  start_ready_out <= 1'b0;
                  busy_out        <= 1'b1;
               end
            end
            ST_RUN: begin
               if (cnt_r == CNT_END) begin
                  state_r          <= ST_DONE;
                  sum_out          <= sum_sr_r;
                  carry_out        <= carry_r;
                  result_valid_out <= 1'b1;
               end else begin
                  sum_sr_r <= {fa_sum_s, sum_sr_r[WIDTH-1:1]};
                  carry_r  <= fa_carry_s;
                  a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                  b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                  cnt_r    <= cnt_r + CW'(1);
               end
            end
            ST_DONE: begin
               if (result_ready_in) begin
                  state_r          <= ST_IDLE;
                  result_valid_out <= 1'b0;
                  start_ready_out  <= 1'b1;
                  busy_out         <= 1'b0;
               end
            end
            default: begin
               state_r          <= ST_IDLE;
               start_ready_out  <= 1'b1;
               result_valid_out <= 1'b0;
               busy_out         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;
   localparam int W = 8;

   logic         clk_in = 1'b0;
   logic         rst_n_in;
   logic         start_valid_in;
   logic         start_ready_out;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin_in;
`ifdef SERIAL_ADD_SUB_EN
   logic         op_sub_in;
`endif
   logic         result_valid_out;
   logic         result_ready_in;
   logic [W-1:0] sum_out;
   logic         carry_out;
   logic         busy_out;

   int checks   = 0;
   int failures = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .start_valid_in   (start_valid_in),
      .start_ready_out  (start_ready_out),
      .a_in             (a_in),
      .b_in             (b_in),
      .cin_in           (cin_in),
`ifdef SERIAL_ADD_SUB_EN
      .op_sub_in        (op_sub_in),
`endif
      .result_valid_out (result_valid_out),
      .result_ready_in  (result_ready_in),
      .sum_out          (sum_out),
      .carry_out        (carry_out),
      .busy_out         (busy_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // One full transaction; hold = cycles the consumer stalls once the result is valid.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input int hold);
      logic [W:0] exp;
      int         n;
      if (sub) begin
         exp[W-1:0] = a - b;
         exp[W]     = (a >= b);
      end else begin
         exp = a + b + cin;
      end
      check("start_ready_idle", start_ready_out, 64'd1);
      a_in           = a;
      b_in           = b;
      cin_in         = cin;
`ifdef SERIAL_ADD_SUB_EN
      op_sub_in      = sub;
`endif
      start_valid_in = 1'b1;
      result_ready_in = (hold == 0);
      tick();
      n = 0;
      while (!result_valid_out && n < 40) begin
         check("start_ready_run", start_ready_out, 64'd0);
         check("busy_run", busy_out, 64'd1);
         a_in           = W'($urandom);
         b_in           = W'($urandom);
         cin_in         = 1'($urandom);
         start_valid_in = 1'($urandom);
         tick();
         n++;
      end
      check("latency", n, W + 1);
      check("sum", sum_out, exp[W-1:0]);
      check("carry", carry_out, exp[W]);
      for (int i = 0; i < hold; i++) begin
         start_valid_in = 1'($urandom);
         a_in           = W'($urandom);
         tick();
         check("hold_valid", result_valid_out, 64'd1);
         check("hold_sum", sum_out, exp[W-1:0]);
         check("hold_carry", carry_out, exp[W]);
         check("hold_start_ready", start_ready_out, 64'd0);
      end
      result_ready_in = 1'b1;
      tick();
      start_valid_in  = 1'b0;
      result_ready_in = 1'b0;
      check("idle_valid", result_valid_out, 64'd0);
      check("idle_start_ready", start_ready_out, 64'd1);
      check("idle_busy", busy_out, 64'd0);
      check("sum_persist", sum_out, exp[W-1:0]);
      check("carry_persist", carry_out, exp[W]);
   endtask

   initial begin
      rst_n_in        = 1'b0;
      start_valid_in  = 1'b0;
      result_ready_in = 1'b0;
      a_in            = '0;
      b_in            = '0;
      cin_in          = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      op_sub_in       = 1'b0;
`endif
      tick();
      tick();
      rst_n_in = 1'b1;
      tick();
      check("rst_start_ready", start_ready_out, 64'd1);
      check("rst_valid", result_valid_out, 64'd0);
      check("rst_sum", sum_out, 64'd0);
      check("rst_carry", carry_out, 64'd0);
      check("rst_busy", busy_out, 64'd0);

      run_op(8'h3C, 8'h05, 1'b0, 1'b0, 0);
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
      run_op(8'h00, 8'h00, 1'b1, 1'b0, 0);
      run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 5);

      // Abort four cycles into RUN; the partial result must never surface.
      a_in           = 8'h77;
      b_in           = 8'h99;
      cin_in         = 1'b1;
      start_valid_in = 1'b1;
      tick();
      start_valid_in = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst_n_in = 1'b0;
      tick();
      rst_n_in = 1'b1;
      check("abort_start_ready", start_ready_out, 64'd1);
      check("abort_valid", result_valid_out, 64'd0);
      check("abort_sum", sum_out, 64'd0);
      check("abort_carry", carry_out, 64'd0);
      check("abort_busy", busy_out, 64'd0);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("abort_no_valid", result_valid_out, 64'd0);
      end
      run_op(8'h10, 8'h20, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
      run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
      run_op(8'h07, 8'h05, 1'b0, 1'b1, 0);
`endif

      for (int k = 0; k < 20; k++) begin
`ifdef SERIAL_ADD_SUB_EN
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
`else
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 3)));
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
